// File: rtl/register_q_pkg.sv
// Shared definitions for the register_q shift/load register.
// Holds the 2-bit operation select encoding and the default register width.
package register_q_pkg;

  localparam int DEFAULT_WIDTH = 9;

  // Operation select, ordered so that a higher code wins when the top level
  // priority-encodes simultaneous requests.
  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_LOAD   = 2'd1,
    SEL_RSHIFT = 2'd2,
    SEL_LSHIFT = 2'd3
  } sel_e;

endpackage : register_q_pkg

// File: rtl/register_q_if.sv
// Control/data bundle for register_q.
// The slave modport is the register side and the master modport is the driver side.
// Optional macro REGISTER_Q_NOT_Q_EN adds the inverted output not_q.
interface register_q_if
  import register_q_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load;
  logic             rshift;
  logic             lshift;
  logic             right_shift_entry_wire;
  logic             left_shift_entry_wire;
  logic [WIDTH-1:0] qq;
  logic [WIDTH-1:0] q;
`ifdef REGISTER_Q_NOT_Q_EN
  logic [WIDTH-1:0] not_q;
`endif

`ifdef REGISTER_Q_NOT_Q_EN
  modport slave (
    input  load, rshift, lshift, right_shift_entry_wire, left_shift_entry_wire, qq,
    output q, not_q
  );
  modport master (
    output load, rshift, lshift, right_shift_entry_wire, left_shift_entry_wire, qq,
    input  q, not_q
  );
`else
  modport slave (
    input  load, rshift, lshift, right_shift_entry_wire, left_shift_entry_wire, qq,
    output q
  );
  modport master (
    output load, rshift, lshift, right_shift_entry_wire, left_shift_entry_wire, qq,
    input  q
  );
`endif

endinterface : register_q_if

// File: rtl/register_q_cell.sv
// One bit of register_q: a 4:1 next-state mux feeding an async-reset flop.
// The top level supplies the neighbour bits, so the cell only knows its own
// hold value plus the three candidate next values.
module register_q_cell
  import register_q_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  sel_e i_sel,
  input  logic i_load_bit,
  input  logic i_rshift_bit,
  input  logic i_lshift_bit,
  output logic o_q
);

  logic r_q;
  logic w_d;

  // Next-state selection for this bit.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves w_d unassigned (no latch).
    w_d = r_q;
    case (i_sel)
      SEL_HOLD:   w_d = r_q;
      SEL_LOAD:   w_d = i_load_bit;
      SEL_RSHIFT: w_d = i_rshift_bit;
      SEL_LSHIFT: w_d = i_lshift_bit;
      default:    w_d = r_q;
    endcase
  end

  // Storage flop; reset clears the bit immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every cell samples neighbours' pre-edge values.
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule : register_q_cell

// File: rtl/register_q.sv
// register_q: WIDTH-bit register with parallel load, right shift and left shift.
// q[0] acts as the Booth q[-1] bit: a left shift clears it and never moves it
// into q[1]; q[1] takes left_shift_entry_wire instead (division LSB).
// Optional macro REGISTER_Q_NOT_Q_EN drives not_q = ~q on the interface.
module register_q
  import register_q_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic         clk,
  input  logic         rst_n,
  register_q_if.slave  bus
);

  sel_e             w_sel;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_rshift_bits;
  logic [WIDTH-1:0] w_lshift_bits;

  // Priority encoder: lshift > rshift > load > hold.
  always_comb begin
    w_sel = SEL_HOLD;
    if (bus.lshift) begin
      w_sel = SEL_LSHIFT;
    end else if (bus.rshift) begin
      w_sel = SEL_RSHIFT;
    end else if (bus.load) begin
      w_sel = SEL_LOAD;
    end
  end

  // Candidate next values for the shift operations.
  assign w_rshift_bits = {bus.right_shift_entry_wire, w_q[WIDTH-1:1]};
  assign w_lshift_bits = {w_q[WIDTH-2:1], bus.left_shift_entry_wire, 1'b0};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    register_q_cell u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_sel        (w_sel),
      .i_load_bit   (bus.qq[gi]),
      .i_rshift_bit (w_rshift_bits[gi]),
      .i_lshift_bit (w_lshift_bits[gi]),
      .o_q          (w_q[gi])
    );
  end

  assign bus.q = w_q;

`ifdef REGISTER_Q_NOT_Q_EN
  assign bus.not_q = ~w_q;
`endif

endmodule : register_q

// File: tb/tb_register_q.sv
// Self-checking bench for register_q: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_register_q;
  import register_q_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  register_q_if #(.WIDTH(W)) bus ();

  register_q #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: arithmetic on the whole word, priority as written.
  logic [W-1:0] m_q = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
    end else if (bus.lshift) begin
      m_q <= ((m_q << 1) & {{(W-2){1'b1}}, 2'b00}) | (W'(bus.left_shift_entry_wire) << 1);
    end else if (bus.rshift) begin
      m_q <= (m_q >> 1) | {bus.right_shift_entry_wire, {(W-1){1'b0}}};
    end else if (bus.load) begin
      m_q <= bus.qq;
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  bit run = 1'b0;
  always @(negedge clk) begin
    if (run) begin
      check("model_q", bus.q, m_q);
`ifdef REGISTER_Q_NOT_Q_EN
      check("model_not_q", bus.not_q, ~m_q);
`endif
    end
  end

  // Called at posedge+1: set inputs, then advance to just after the next edge.
  task automatic apply(input logic ld, input logic rs, input logic ls,
                       input logic re, input logic le, input logic [W-1:0] d);
    bus.load                   = ld;
    bus.rshift                 = rs;
    bus.lshift                 = ls;
    bus.right_shift_entry_wire = re;
    bus.left_shift_entry_wire  = le;
    bus.qq                     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.load = 1'b0; bus.rshift = 1'b0; bus.lshift = 1'b0;
    bus.right_shift_entry_wire = 1'b0; bus.left_shift_entry_wire = 1'b0;
    bus.qq = '0;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_q", bus.q, 9'h000);
`ifdef REGISTER_Q_NOT_Q_EN
    check("reset_not_q", bus.not_q, 9'h1FF);
`endif
    rst_n = 1'b1;
    run   = 1'b1;

    // Load then right shift.
    apply(1, 0, 0, 0, 0, 9'h017); check("load_017", bus.q, 9'h017);
    apply(1, 0, 0, 0, 0, 9'h06A); check("load_06A", bus.q, 9'h06A);
    apply(0, 1, 0, 0, 0, 9'h000); check("rshift_035", bus.q, 9'h035);

    // Left shift with entry 1; q[0] must stay 0.
    apply(0, 0, 1, 0, 1, 9'h000); check("lshift_06A", bus.q, 9'h06A);
    check("lshift1_q0", {{(W-1){1'b0}}, bus.q[0]}, '0);
    apply(0, 0, 1, 0, 1, 9'h000); check("lshift_0D6", bus.q, 9'h0D6);
    check("lshift2_q0", {{(W-1){1'b0}}, bus.q[0]}, '0);

    // Right-shift entry bit fills from the top.
    apply(1, 0, 0, 0, 0, 9'h000); check("load_000", bus.q, 9'h000);
    for (int i = 0; i < 4; i++) apply(0, 1, 0, 1, 0, 9'h000);
    check("rshift_entry_1E0", bus.q, 9'h1E0);

    // All requests at once: left shift wins; then hold.
    apply(1, 0, 0, 0, 0, 9'h0AA); check("load_0AA", bus.q, 9'h0AA);
    apply(1, 1, 1, 0, 0, 9'h1FF); check("priority_154", bus.q, 9'h154);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 9'h1FF); check("hold_154", bus.q, 9'h154);
    end

    // load+rshift together performs the right shift.
    apply(1, 1, 0, 1, 0, 9'h000); check("load_rshift", bus.q, 9'h1AA);

    // Reset mid-cycle with a load pending: immediate clear, no clock edge needed.
    apply(1, 0, 0, 0, 0, 9'h1FF);
    bus.rshift = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("midreset_q", bus.q, 9'h000);
`ifdef REGISTER_Q_NOT_Q_EN
    check("midreset_not_q", bus.not_q, 9'h1FF);
`endif
    @(posedge clk); #1;
    check("reset_hold_edge", bus.q, 9'h000);
    bus.load = 1'b0; bus.rshift = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_release", bus.q, 9'h000);

    // Randomized traffic; the falling-edge compare process checks each cycle.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            1'($urandom), 1'($urandom), W'($urandom));
    end

    apply(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_register_q
